// File: rtl/icache_axi_bridge.sv
// Instruction-cache line refill bridge: one 4-beat AXI4 INCR read per accepted request.
// Optional performance counters are built only when ICACHE_BRIDGE_PERF_CNT_EN is defined.
module icache_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cpu_ren,
   input  logic [31:0]  cpu_raddr,
   output logic         ren_received,
   output logic         dev_rrdy,
   output logic         dev_rvalid,
   output logic [127:0] dev_rdata,
   output logic         flush_flag_valid,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [3:0]   rid,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [31:0]  perf_refill_cnt,
   output logic [31:0]  perf_busy_cnt
);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t         state_q, state_d;
   logic [27:0]    addr_q, addr_d;
   logic [1:0]     beatCnt_q, beatCnt_d;
   logic [127:0]   line_q, line_d;
   logic           unused_bits;

   // Response status is not reported to the cache, and the line offset is irrelevant.
   assign unused_bits = ^{rresp, cpu_raddr[3:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         beatCnt_q <= '0;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         beatCnt_q <= beatCnt_d;
         line_q    <= line_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      beatCnt_d        = beatCnt_q;
      line_d           = line_q;
      ren_received     = 1'b0;
      dev_rrdy         = 1'b0;
      dev_rvalid       = 1'b0;
      arvalid          = 1'b0;
      araddr           = '0;
      arlen            = '0;
      arsize           = '0;
      arburst          = '0;
      arid             = '0;
      rready           = 1'b0;
      flush_flag_valid = 1'b0;

      case (state_q)
         IDLE: begin
            dev_rrdy = 1'b1;
            if (cpu_ren) begin
               ren_received = 1'b1;
               addr_d       = cpu_raddr[31:4];
               beatCnt_d    = '0;
               line_d       = '0;
               state_d      = AR;
            end
         end
         AR: begin
            arvalid = 1'b1;
            araddr  = {addr_q, 4'b0000};
            arlen   = 8'd3;
            arsize  = 3'b010;
            arburst = 2'b01;
            arid    = AXI_ID;
            if (arready) begin
               state_d = R;
            end
         end
         R: begin
            rready = 1'b1;
            // Beats tagged for another master are acknowledged but never stored.
            if (rvalid && (rid == AXI_ID)) begin
               line_d[{beatCnt_q, 5'b00000} +: 32] = rdata;
               if (beatCnt_q != 2'd3) begin
                  beatCnt_d = beatCnt_q + 2'd1;
               end
               if (rlast) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            dev_rvalid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      flush_flag_valid = ren_received | (state_q != IDLE);

      // While reset is held the bridge presents itself as idle with nothing owed.
      if (rst) begin
         ren_received     = 1'b0;
         dev_rrdy         = 1'b1;
         dev_rvalid       = 1'b0;
         arvalid          = 1'b0;
         araddr           = '0;
         arlen            = '0;
         arsize           = '0;
         arburst          = '0;
         arid             = '0;
         rready           = 1'b0;
         flush_flag_valid = 1'b0;
      end
   end

   assign dev_rdata = rst ? '0 : line_q;

`ifdef ICACHE_BRIDGE_PERF_CNT_EN
   logic [31:0] refillCnt_q, refillCnt_d;
   logic [31:0] busyCnt_q, busyCnt_d;

   always_comb begin
      refillCnt_d = refillCnt_q;
      busyCnt_d   = busyCnt_q;
      if (state_q == DONE) begin
         refillCnt_d = refillCnt_q + 32'd1;
      end
      if (state_q != IDLE) begin
         busyCnt_d = busyCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refillCnt_q <= '0;
         busyCnt_q   <= '0;
      end else begin
         refillCnt_q <= refillCnt_d;
         busyCnt_q   <= busyCnt_d;
      end
   end

   assign perf_refill_cnt = rst ? '0 : refillCnt_q;
   assign perf_busy_cnt   = rst ? '0 : busyCnt_q;
`else
   assign perf_refill_cnt = '0;
   assign perf_busy_cnt   = '0;
`endif

endmodule

// File: tb/tb_icache_axi_bridge.sv
// Self-checking bench for icache_axi_bridge: scripted AXI slave plus a line scoreboard.
// Perf-counter expectations follow ICACHE_BRIDGE_PERF_CNT_EN.
module tb_icache_axi_bridge;

   localparam logic [3:0] ID = 4'h5;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_ren;
   logic [31:0]  cpu_raddr;
   logic         ren_received;
   logic         dev_rrdy;
   logic         dev_rvalid;
   logic [127:0] dev_rdata;
   logic         flush_flag_valid;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [31:0]  perf_refill_cnt;
   logic [31:0]  perf_busy_cnt;

   int           total = 0;
   int           bad = 0;
   int           cycleCnt = 0;
   logic [127:0] expQ[$];

   icache_axi_bridge #(.AXI_ID(ID)) dut (
      .clk(clk), .rst(rst), .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
      .ren_received(ren_received), .dev_rrdy(dev_rrdy), .dev_rvalid(dev_rvalid),
      .dev_rdata(dev_rdata), .flush_flag_valid(flush_flag_valid),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready), .perf_refill_cnt(perf_refill_cnt), .perf_busy_cnt(perf_busy_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt = cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every delivered line is compared against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (dev_rvalid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_rvalid", 128'(1), 128'(0));
         end else begin
            checkOutput("line", dev_rdata, expQ.pop_front());
         end
      end
   end

   // One refill: accept, AR with optional stall, R with optional gaps/foreign beat, DONE.
   task automatic applyStimulus(input logic [31:0] addr, input int stall, input bit toggle,
                                input int foreignAt, input int nBeats,
                                input logic [127:0] beats, input bit renInDone);
      logic [127:0] expLine;
      int tAcc, rCycles, beatIdx;
      bit gap, foreignDone;
      expLine = '0;
      for (int i = 0; i < nBeats; i++) expLine[i*32 +: 32] = beats[i*32 +: 32];
      cpu_ren = 1'b1;
      cpu_raddr = addr;
      #1;
      checkOutput("ren_received", 128'(ren_received), 128'(1));
      checkOutput("rrdy_idle", 128'(dev_rrdy), 128'(1));
      checkOutput("flush_on_accept", 128'(flush_flag_valid), 128'(1));
      expQ.push_back(expLine);
      tAcc = cycleCnt;
      @(posedge clk); #1;
      cpu_ren = 1'b0;
      for (int k = 0; k <= stall; k++) begin
         arready = (k == stall);
         #1;
         checkOutput("arvalid", 128'(arvalid), 128'(1));
         checkOutput("araddr", 128'(araddr), 128'({addr[31:4], 4'h0}));
         if (k == 0) begin
            checkOutput("ar_fields", 128'({arid, arlen, arsize, arburst}),
                        128'({ID, 8'd3, 3'b010, 2'b01}));
            checkOutput("rrdy_busy", 128'(dev_rrdy), 128'(0));
         end
         @(posedge clk); #1;
      end
      arready = 1'b0;
      beatIdx = 0; gap = 1'b0; foreignDone = 1'b0; rCycles = 0;
      while (beatIdx < nBeats && rCycles < 64) begin
         rCycles++;
         if (toggle && gap) begin
            rvalid = 1'b0;
         end else if (beatIdx == foreignAt && !foreignDone) begin
            rvalid = 1'b1; rid = ID + 4'd1; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
            foreignDone = 1'b1;
         end else begin
            rvalid = 1'b1; rid = ID; rdata = beats[beatIdx*32 +: 32];
            rlast = (beatIdx == nBeats - 1);
            beatIdx++;
         end
         gap = toggle ? !gap : 1'b0;
         #1;
         if (rCycles == 1) checkOutput("rready", 128'(rready), 128'(1));
         checkOutput("no_early_rvalid", 128'(dev_rvalid), 128'(0));
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0;
      if (renInDone) cpu_ren = 1'b1;
      #1;
      checkOutput("dev_rvalid", 128'(dev_rvalid), 128'(1));
      checkOutput("latency", 128'(cycleCnt - tAcc), 128'(2 + stall + rCycles));
      if (renInDone) checkOutput("no_accept_in_done", 128'(ren_received), 128'(0));
      @(posedge clk); #1;
      checkOutput("rvalid_one_cycle", 128'(dev_rvalid), 128'(0));
      checkOutput("back_to_idle", 128'(dev_rrdy), 128'(1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [127:0] base;
      logic [127:0] rnd;
      base = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      rst = 1'b1; cpu_ren = 1'b1; cpu_raddr = 32'h1234_5678;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_rrdy", 128'(dev_rrdy), 128'(1));
      checkOutput("rst_outs", 128'({ren_received, dev_rvalid, arvalid, rready, flush_flag_valid}), 128'(0));
      checkOutput("rst_rdata", dev_rdata, 128'(0));
      rst = 1'b0; cpu_ren = 1'b0;

      $display("[TB] basic refill, then request raised in DONE");
      applyStimulus(32'h1C00_0014, 0, 1'b0, -1, 4, base, 1'b1);
      $display("[TB] arready stalled 3 cycles");
      applyStimulus(32'h2000_004C, 3, 1'b0, -1, 4, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
      $display("[TB] toggling rvalid with foreign beat");
      applyStimulus(32'h1C00_0014, 0, 1'b1, 1, 4, base, 1'b0);
      $display("[TB] early rlast");
      applyStimulus(32'h0000_0100, 0, 1'b0, -1, 2, {64'h0, 32'h22, 32'h11}, 1'b0);

      $display("[TB] reset mid-burst");
      cpu_ren = 1'b1; cpu_raddr = 32'h3000_0000;
      #1;
      checkOutput("rst_test_accept", 128'(ren_received), 128'(1));
      @(posedge clk); #1;
      cpu_ren = 1'b0; arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         rvalid = 1'b1; rid = ID; rdata = 32'hBB00 + b; rlast = 1'b0;
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rst = 1'b1;
      #1;
      checkOutput("rst_during_rrdy", 128'(dev_rrdy), 128'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("after_rst_rrdy", 128'(dev_rrdy), 128'(1));
      checkOutput("after_rst_flush", 128'(flush_flag_valid), 128'(0));
      checkOutput("after_rst_quiet", 128'({dev_rvalid, rready, arvalid}), 128'(0));
      applyStimulus(32'h3000_0008, 1, 1'b0, -1, 4, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);

      $display("[TB] pseudo-random refills");
      for (int n = 0; n < 4; n++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus($urandom, int'($urandom_range(0, 2)), 1'(n % 2), -1,
                       int'($urandom_range(1, 4)), rnd, 1'b0);
      end

      $display("[TB] performance counters");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(32'h1C00_0014, 0, 1'b0, -1, 4, base, 1'b0);
      applyStimulus(32'h1C00_0014, 0, 1'b0, -1, 4, base, 1'b0);
`ifdef ICACHE_BRIDGE_PERF_CNT_EN
      checkOutput("perf_refill", 128'(perf_refill_cnt), 128'(2));
      checkOutput("perf_busy", 128'(perf_busy_cnt), 128'(12));
`else
      checkOutput("perf_refill", 128'(perf_refill_cnt), 128'(0));
      checkOutput("perf_busy", 128'(perf_busy_cnt), 128'(0));
`endif
      repeat (2) @(posedge clk);
      #1;
      checkOutput("queue_empty", 128'(expQ.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_axi_bridge.md
ICACHE_AXI_BRIDGE -- requirements
Module: icache_axi_bridge

Interface
REQ-001 Parameter: AXI_ID, default 4'h0, ARID driven on every read burst; R beats with other RID are discarded.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_ren  input  1  line-refill request from instruction cache, held until ren_received.
REQ-005 cpu_raddr  input  32  refill address, bits [3:0] ignored.
REQ-006 ren_received  output  1  request accepted this cycle.
REQ-007 dev_rrdy  output  1  bridge idle, able to accept.
REQ-008 dev_rvalid  output  1  one-cycle pulse, 128-bit line valid.
REQ-009 dev_rdata  output  128  assembled line, word k at [32k+31:32k].
REQ-010 flush_flag_valid  output  1  a dev_rvalid pulse is owed to the cache.
REQ-011 arid 4 / araddr 32 / arlen 8 / arsize 3 / arburst 2 / arvalid 1  outputs  AXI4 read address channel.
REQ-012 arready  input  1  AXI4 read address ready.
REQ-013 rid 4 / rdata 32 / rresp 2 / rlast 1 / rvalid 1  inputs  AXI4 read data channel.
REQ-014 rready  output  1  AXI4 read data ready.
REQ-015 perf_refill_cnt, perf_busy_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states IDLE, AR, R, DONE; exactly one active.
REQ-017 IDLE: dev_rrdy=1; if cpu_ren=1, ren_received=1 combinationally same cycle, latch {cpu_raddr[31:4],4'b0}, clear line buffer to 0, beat counter to 0, go AR.
REQ-018 ren_received=0 in every state other than IDLE; cpu_ren ignored outside IDLE.
REQ-019 AR: arvalid=1, araddr=latched address, arlen=8'd3, arsize=3'b010, arburst=2'b01, arid=AXI_ID; AR fields held stable while arvalid&!arready; on arready go R.
REQ-020 arvalid=0 outside AR; AR fields 0 outside AR.
REQ-021 R: rready=1; each rvalid beat with rid==AXI_ID writes rdata into word[beat counter], counter increments (2-bit, saturating at 3); rresp value ignored, data stored regardless.
REQ-022 R: beat with rid==AXI_ID and rlast=1 moves to DONE, even if fewer than 4 beats arrived (unfilled words stay 0); beats with rid!=AXI_ID are acknowledged and dropped.
REQ-023 DONE: dev_rvalid=1 for exactly that cycle, then IDLE unconditionally.
REQ-024 dev_rdata holds the last delivered line until the next acceptance clears the buffer; dev_rdata is valid only when dev_rvalid=1.
REQ-025 flush_flag_valid = ren_received | (state != IDLE); every accepted request produces exactly one dev_rvalid pulse; the bridge never drops a request.
REQ-026 Minimum latency, arready and rvalid always high: accept at T, arvalid at T+1, beats T+2..T+5, dev_rvalid at T+6.
REQ-027 cpu_ren asserted in DONE is not accepted before the following IDLE cycle (no back-to-back acceptance in DONE).

Reset
REQ-028 rst=1 at any edge forces IDLE, beat counter 0, line buffer 0, perf counters 0, from the next cycle onward.
REQ-029 Outputs during and after reset: dev_rrdy=1, all other outputs 0.
REQ-030 Reset mid-burst abandons the transaction without issuing dev_rvalid; the AXI interconnect shares the same reset.

Configuration
REQ-031 Macro ICACHE_BRIDGE_PERF_CNT_EN defined: perf_refill_cnt increments by 1 on each dev_rvalid, perf_busy_cnt increments by 1 each cycle state!=IDLE; both wrap modulo 2^32.
REQ-032 Macro undefined: both perf ports tied to constant 0, no counter registers synthesized; all other behaviour identical.

Verification
REQ-033 cpu_ren=1, cpu_raddr=0x1C00_0014, arready/rvalid always 1, rdata=0xA0,0xA1,0xA2,0xA3 -> araddr=0x1C00_0010 at T+1, dev_rvalid at T+6 only, dev_rdata=0x000000A3_000000A2_000000A1_000000A0.
REQ-034 arready low 3 cycles in AR -> arvalid and araddr stable throughout, dev_rvalid delayed 3 cycles vs REQ-033.
REQ-035 rvalid toggling 1,0,1,0...; one beat with rid=AXI_ID+1 inserted -> foreign beat dropped, line identical to REQ-033.
REQ-036 rlast on second beat (data 0x11,0x22) -> dev_rvalid next cycle, dev_rdata=0x00000000_00000000_00000022_00000011.
REQ-037 rst=1 during R after 2 beats -> no dev_rvalid, dev_rrdy=1 and flush_flag_valid=0 next cycle; new request then completes normally.
REQ-038 With ICACHE_BRIDGE_PERF_CNT_EN, two REQ-033 refills back-to-back -> perf_refill_cnt=2, perf_busy_cnt=12; without macro both read 0.
